hall_call_register: RTL and testbench
=====================================

# hall_call_register

Latches momentary hall-call push-buttons into persistent requests and feeds them to the elevator controller's `button_up` / `button_down` inputs. It clears each request when the car is serving it: at that floor, door open, and travelling in a compatible direction. The car state is taken from the controller's `position` / `open` / `direction` outputs. The block also reports the pending-call count and an oldest-call indicator for the dispatcher and display logic.

## Interface
Parameters:
- `AGE_W`, default 4: width of each per-call age counter; only used when `HALL_CALL_AGE_EN` is defined.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `hall_up_raw` input 3: raw up buttons; [0] is floor 1, [1] is floor 2, [2] is floor 3. Level, any duration.
- `hall_down_raw` input 3: raw down buttons; [0] is floor 2, [1] is floor 3, [2] is floor 4. Level, any duration.
- `position` input 3: car position from the controller. Floor k is 2(k-1); odd values mean the car is between floors.
- `open` input 1: door state from the controller; 1 = open.
- `direction` input 2: from the controller; 00 stop, 01 up, 10 down.
- `button_up` output 3: latched up calls, same indexing as `hall_up_raw`.
- `button_down` output 3: latched down calls, same indexing as `hall_down_raw`.
- `pending_count` output 3: number of latched calls, 0..6.
- `oldest_valid` output 1: 1 when at least one call is latched.
- `oldest_idx` output 3: call slot number. 0..2 are up[0..2]; 3..5 are down[0..2].

## Operation
- **Edge detect.** One register per raw input holds the previous value.
  - A press is raw=1 while the register holds 0.
  - A held button generates one press only.
- **Set.** A press on slot s sets the latch for s at that clock edge.
- **Service match.** A slot is at-floor when `open`=1, `position` is even, and `position` equals the slot's floor: up[i] → 2i, down[i] → 2(i+1).
- **Clear.**
  - An up slot clears when at-floor and `direction` != 10.
  - A down slot clears when at-floor and `direction` != 01.
  - `direction`=00 clears both slots at that floor.
- **Priority.** Clear beats set in the same cycle: a press at a floor currently being served never latches.
- **Retained calls.** A latched call stays set until cleared; further presses on it have no effect.
- **Count.** `pending_count` is the popcount of the six latches, combinational from registers.
- **Oldest call.** `oldest_idx` is the latched slot with the greatest age. Ties go to the lowest slot number.
  - When nothing is latched: `oldest_valid`=0 and `oldest_idx`=0.
- **Illegal inputs.** `direction`=11 is treated as 00. Odd `position` never clears anything.

## Timing
- **Reset (asynchronous):** all latches, edge registers and ages go to 0.
  - Outputs then read `button_up`=000, `button_down`=000, `pending_count`=0, `oldest_valid`=0, `oldest_idx`=0.
- **Release of reset.**
  - The edge registers are 0, so a button already held at release registers as a press on the first edge.
  - Reset asserted mid-operation discards all calls immediately.
- **Latency.**
  - `button_*` are registered outputs.
  - A press sampled at edge n gives the output high after edge n.
  - A clear sampled at edge n gives the output low after edge n.
  - `button_*` are stable across the falling edge on which the controller samples.
- **Combinational outputs.** `pending_count` and `oldest_*` are combinational from the latch and age registers, with no input-to-output paths.

## Configuration
- **`HALL_CALL_AGE_EN` defined:**
  - Each slot has an `AGE_W`-bit counter.
  - The counter is 0 on set and increments by 1 every cycle while latched.
  - It saturates at 2^AGE_W − 1 and returns to 0 on clear or reset.
  - The oldest call is chosen by age, as above.
- **`HALL_CALL_AGE_EN` undefined:**
  - No counters are built and `AGE_W` is ignored.
  - `oldest_idx` is the lowest-numbered latched slot.
  - `oldest_valid` = OR of the latches.

## Test plan
- **Reset and single press.** Assert `reset_n`=0 mid-run → all outputs zero. Release, then pulse `hall_up_raw`=001 for one cycle → `button_up`=001, `pending_count`=1, `oldest_idx`=0.
- **Held button after service.** Hold `hall_down_raw`[1]=1 for 10 cycles. Serve with `position`=100, `open`=1, `direction`=00 → `button_down`[1] clears and does not re-latch while held. Release and press again → latches.
- **Direction filter.** Latch both up[1] and down[0]; both are at floor 2. Drive `position`=010, `open`=1, `direction`=01 → only up[1] clears. Then `direction`=10 → down[0] clears.
- **Simultaneous set and clear.** Press up[2] in the same cycle as `position`=100, `open`=1, `direction`=01 → `button_up`[2] stays 0. Same press with `open`=0 → latches.
- **Age saturation and ordering (`HALL_CALL_AGE_EN`, `AGE_W`=2).**
  - Latch down[2], then up[0] 1 cycle later → `oldest_idx`=5.
  - After 3 more cycles both ages are saturated at 3 → tie → `oldest_idx`=0.
- **No-age build.** Latch down[0] then up[2] → `oldest_idx`=2. `pending_count`=2; odd `position`=011 with `open`=1 clears nothing.

Source files
------------

// File: rtl/hall_call_register.sv
// Hall-call latch bank: edge-detects raw hall buttons, holds requests until served, reports count/oldest.
// Optional per-call age tracking is enabled by defining HALL_CALL_AGE_EN.
module hall_call_register #(
  parameter int unsigned AGE_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] hall_up_raw,
  input  logic [2:0] hall_down_raw,
  input  logic [2:0] position,
  input  logic       open,
  input  logic [1:0] direction,
  output logic [2:0] button_up,
  output logic [2:0] button_down,
  output logic [2:0] pending_count,
  output logic       oldest_valid,
  output logic [2:0] oldest_idx
);

  // Slots 0..2 are up[0..2], slots 3..5 are down[0..2].
  logic [5:0] raw;
  logic [5:0] prev_q;
  logic [5:0] latch_q, latch_d;
  logic [5:0] press;
  logic [5:0] clr;
  logic       dir_up, dir_dn;

  function automatic logic [2:0] slot_pos(input int s);
    if (s < 3) return 3'(2 * s);
    else       return 3'(2 * (s - 2));
  endfunction

  assign raw    = {hall_down_raw, hall_up_raw};
  assign dir_up = (direction == 2'b01);
  assign dir_dn = (direction == 2'b10);
  assign press  = raw & ~prev_q;

  always_comb begin
    clr = '0;
    for (int s = 0; s < 6; s++) begin
      if (open && !position[0] && position == slot_pos(s)) begin
        clr[s] = (s < 3) ? !dir_dn : !dir_up;
      end
    end
    // Clear wins over a same-cycle press.
    latch_d = (latch_q | press) & ~clr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      latch_q <= '0;
    end else begin
      prev_q  <= raw;
      latch_q <= latch_d;
    end
  end

  assign button_up   = latch_q[2:0];
  assign button_down = latch_q[5:3];

  always_comb begin
    pending_count = '0;
    for (int s = 0; s < 6; s++) begin
      pending_count = pending_count + 3'(latch_q[s]);
    end
  end

`ifdef HALL_CALL_AGE_EN
  localparam logic [AGE_W-1:0] AgeMax = '1;

  logic [AGE_W-1:0] age_q [6];
  logic [AGE_W-1:0] age_d [6];
  logic [AGE_W-1:0] best_age;

  always_comb begin
    for (int s = 0; s < 6; s++) begin
      age_d[s] = '0;
      // Count only while the call survives this edge; a fresh set starts at zero.
      if (latch_q[s] && latch_d[s]) begin
        age_d[s] = (age_q[s] == AgeMax) ? age_q[s] : age_q[s] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < 6; s++) age_q[s] <= '0;
    end else begin
      for (int s = 0; s < 6; s++) age_q[s] <= age_d[s];
    end
  end

  always_comb begin
    oldest_valid = 1'b0;
    oldest_idx   = '0;
    best_age     = '0;
    for (int s = 0; s < 6; s++) begin
      // Strict compare keeps the lowest slot on ties.
      if (latch_q[s] && (!oldest_valid || age_q[s] > best_age)) begin
        oldest_valid = 1'b1;
        oldest_idx   = 3'(s);
        best_age     = age_q[s];
      end
    end
  end
`else
  always_comb begin
    oldest_valid = 1'b0;
    oldest_idx   = '0;
    for (int s = 0; s < 6; s++) begin
      if (latch_q[s] && !oldest_valid) begin
        oldest_valid = 1'b1;
        oldest_idx   = 3'(s);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hall_call_register.sv
// Scoreboard bench for hall_call_register: a behavioural model queues expected outputs per cycle.
// Age-dependent expectations follow HALL_CALL_AGE_EN as seen by the bench.
module tb_hall_call_register;

  localparam int unsigned AGE_W = 2;
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic       clk;
  logic       reset_n;
  logic [2:0] hall_up_raw, hall_down_raw, position;
  logic       open;
  logic [1:0] direction;
  logic [2:0] button_up, button_down, pending_count, oldest_idx;
  logic       oldest_valid;

  hall_call_register #(.AGE_W(AGE_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hall_up_raw  (hall_up_raw),
    .hall_down_raw(hall_down_raw),
    .position     (position),
    .open         (open),
    .direction    (direction),
    .button_up    (button_up),
    .button_down  (button_down),
    .pending_count(pending_count),
    .oldest_valid (oldest_valid),
    .oldest_idx   (oldest_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] up;
    logic [2:0] dn;
    logic [2:0] cnt;
    logic       vld;
    logic [2:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [5:0] m_lat, m_prev;
  int         m_age[6];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   best;
    e.up  = m_lat[2:0];
    e.dn  = m_lat[5:3];
    e.cnt = 3'($countones(m_lat));
    e.vld = |m_lat;
    e.idx = 3'd0;
    best  = -1;
    for (int s = 0; s < 6; s++) begin
      if (m_lat[s]) begin
`ifdef HALL_CALL_AGE_EN
        if (m_age[s] > best) begin
          best  = m_age[s];
          e.idx = 3'(s);
        end
`else
        if (best < 0) begin
          best  = 0;
          e.idx = 3'(s);
        end
`endif
      end
    end
    return e;
  endfunction

  task automatic step(input string tag, input logic [2:0] up_raw, input logic [2:0] dn_raw,
                      input logic [2:0] pos, input logic opn, input logic [1:0] dir);
    logic [5:0] raw;
    logic [5:0] nxt;
    int         floor_k;
    logic       at, ok, clr;
    exp_t       e;
    hall_up_raw   = up_raw;
    hall_down_raw = dn_raw;
    position      = pos;
    open          = opn;
    direction     = dir;
    raw = {dn_raw, up_raw};
    for (int s = 0; s < 6; s++) begin
      floor_k = (s < 3) ? s + 1 : s - 1;
      at  = opn && !pos[0] && (int'(pos) / 2 + 1 == floor_k);
      ok  = (s < 3) ? (dir != 2'b10) : (dir != 2'b01);
      clr = at && ok;
      if (clr)           nxt[s] = 1'b0;
      else if (m_lat[s]) nxt[s] = 1'b1;
      else               nxt[s] = raw[s] && !m_prev[s];
      if (nxt[s] && m_lat[s]) m_age[s] = (m_age[s] + 1 > AGE_MAX) ? AGE_MAX : m_age[s] + 1;
      else                    m_age[s] = 0;
    end
    m_lat  = nxt;
    m_prev = raw;
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".up"},  32'(button_up),     32'(e.up));
    check_val({tag, ".dn"},  32'(button_down),   32'(e.dn));
    check_val({tag, ".cnt"}, 32'(pending_count), 32'(e.cnt));
    check_val({tag, ".vld"}, 32'(oldest_valid),  32'(e.vld));
    check_val({tag, ".idx"}, 32'(oldest_idx),    32'(e.idx));
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #2;
    check_val({tag, ".up"},  32'(button_up),     32'd0);
    check_val({tag, ".dn"},  32'(button_down),   32'd0);
    check_val({tag, ".cnt"}, 32'(pending_count), 32'd0);
    check_val({tag, ".vld"}, 32'(oldest_valid),  32'd0);
    check_val({tag, ".idx"}, 32'(oldest_idx),    32'd0);
    m_lat  = '0;
    m_prev = '0;
    for (int s = 0; s < 6; s++) m_age[s] = 0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b0;
    hall_up_raw   = '0;
    hall_down_raw = '0;
    position      = '0;
    open          = 1'b0;
    direction     = '0;
    m_lat         = '0;
    m_prev        = '0;
    for (int s = 0; s < 6; s++) m_age[s] = 0;
    @(posedge clk);
    #1;
    do_reset("por");

    // Single press, then a mid-run reset with a button held across release.
    step("press_up0", 3'b001, 3'b000, 3'd0, 1'b0, 2'b00);
    step("idle0",     3'b000, 3'b000, 3'd0, 1'b0, 2'b00);
    step("press_up1", 3'b010, 3'b000, 3'd0, 1'b0, 2'b00);
    hall_up_raw = 3'b100;
    do_reset("mid_rst");
    step("held_rel",  3'b100, 3'b000, 3'd0, 1'b0, 2'b00);

    // Held down[1] through service must not re-latch until released.
    for (int i = 0; i < 10; i++) step("hold_dn1", 3'b000, 3'b010, 3'd0, 1'b0, 2'b00);
    step("serve_f3",  3'b000, 3'b010, 3'd4, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) step("still_held", 3'b000, 3'b010, 3'd4, 1'b0, 2'b00);
    step("release",   3'b000, 3'b000, 3'd4, 1'b0, 2'b00);
    step("repress",   3'b000, 3'b010, 3'd4, 1'b0, 2'b00);

    // Direction filter at floor 2.
    step("lat_u1_d0", 3'b010, 3'b001, 3'd0, 1'b0, 2'b00);
    step("dir_up",    3'b000, 3'b000, 3'd2, 1'b1, 2'b01);
    step("dir_dn",    3'b000, 3'b000, 3'd2, 1'b1, 2'b10);

    // Same-cycle set and clear.
    step("setclr",    3'b100, 3'b000, 3'd4, 1'b1, 2'b01);
    step("gap",       3'b000, 3'b000, 3'd4, 1'b0, 2'b00);
    step("set_closed",3'b100, 3'b000, 3'd4, 1'b0, 2'b01);

    // Age ordering and saturation tie.
    do_reset("rst_age");
    step("lat_d2",    3'b000, 3'b100, 3'd0, 1'b0, 2'b00);
    step("lat_u0",    3'b001, 3'b000, 3'd0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) step("age_run", 3'b000, 3'b000, 3'd0, 1'b0, 2'b00);

    // Lowest-slot ordering and odd position.
    do_reset("rst_order");
    step("lat_d0",    3'b000, 3'b001, 3'd0, 1'b0, 2'b00);
    step("lat_u2",    3'b100, 3'b000, 3'd0, 1'b0, 2'b00);
    step("odd_pos",   3'b000, 3'b000, 3'd3, 1'b1, 2'b00);
    step("dir11",     3'b000, 3'b000, 3'd2, 1'b1, 2'b11);

    // Random traffic including illegal direction and odd positions.
    for (int i = 0; i < 80; i++) begin
      step("rand", 3'($urandom_range(0, 7) & $urandom_range(0, 7)),
           3'($urandom_range(0, 7) & $urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
